// File: rtl/mgmt_spi_master_pkg.sv
// rtl/mgmt_spi_master_pkg.sv - cfg bit positions, reset cfg value and FSM states (MGMT_SPI_MASTER_IRQ_EN)
package mgmt_spi_master_pkg;

  localparam int CFG_W         = 13;
  localparam int CFG_LSB_FIRST = 8;
  localparam int CFG_INVSCK    = 9;
  localparam int CFG_STREAM    = 10;
  localparam int CFG_ENABLE    = 11;
  localparam int CFG_IRQ_EN    = 12;

  // Flag bits [12:8] all clear out of reset; prescale comes from the top parameter.
  localparam logic [4:0] CFG_RESET_FLAGS = 5'b0_0000;

`ifdef MGMT_SPI_MASTER_IRQ_EN
  localparam logic [CFG_W-1:0] CFG_WMASK = 13'h1fff;
`else
  localparam logic [CFG_W-1:0] CFG_WMASK = 13'h0fff;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    TRAIL = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [CFG_W-1:0] cfg_reset_value(input logic [7:0] prescale);
    return {CFG_RESET_FLAGS, prescale};
  endfunction

endpackage

// File: rtl/mgmt_spi_master_if.sv
// rtl/mgmt_spi_master_if.sv - register bus and SPI pins of the management SPI master
interface mgmt_spi_master_if;
  logic        reg_cfg_we;
  logic [15:0] reg_cfg_di;
  logic [15:0] reg_cfg_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [7:0]  reg_dat_di;
  logic [7:0]  reg_dat_do;
  logic        reg_dat_wait;
  logic        sdi;
  logic        csb;
  logic        sck;
  logic        sdo;
  logic        sdoenb;
  logic        irq_out;

  modport master (
    input  reg_cfg_we, reg_cfg_di, reg_dat_we, reg_dat_re, reg_dat_di, sdi,
    output reg_cfg_do, reg_dat_do, reg_dat_wait, csb, sck, sdo, sdoenb, irq_out
  );

  modport slave (
    output reg_cfg_we, reg_cfg_di, reg_dat_we, reg_dat_re, reg_dat_di, sdi,
    input  reg_cfg_do, reg_dat_do, reg_dat_wait, csb, sck, sdo, sdoenb, irq_out
  );
endinterface

// File: rtl/mgmt_spi_master_prescaler.sv
// rtl/mgmt_spi_master_prescaler.sv - half-period tick generator, one tick every H clk cycles
module mgmt_spi_master_prescaler (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] half;

  // A prescale of zero would never tick, so it runs as one.
  assign half   = (prescale_i == 8'd0) ? 8'd1 : prescale_i;
  assign tick_o = en_i && (cnt_q == (half - 8'd1));

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!en_i || tick_o) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mgmt_spi_master.sv
// rtl/mgmt_spi_master.sv - byte-wide SPI master with cfg/data registers (MGMT_SPI_MASTER_IRQ_EN adds irq)
module mgmt_spi_master
  import mgmt_spi_master_pkg::*;
#(
  parameter logic [7:0] DEFAULT_PRESCALE = 8'd2
) (
  input logic               clk,
  input logic               resetn,
  mgmt_spi_master_if.master bus
);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  state_e           state_q, state_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       dat_q, dat_d;
  logic [2:0]       bit_q, bit_d;
  logic             csb_q, csb_d;
  logic             busy, start, tick;
  logic             en_nxt, stream_nxt, lsb_first, last_bit;
  logic             unused_cfg_hi;

  assign unused_cfg_hi = ^bus.reg_cfg_di[15:12];

  // Decisions use the post-write cfg so a same-cycle cfg write governs them.
  assign cfg_d      = bus.reg_cfg_we ? (bus.reg_cfg_di[CFG_W-1:0] & CFG_WMASK) : cfg_q;
  assign en_nxt     = cfg_d[CFG_ENABLE];
  assign stream_nxt = cfg_d[CFG_STREAM];
  assign lsb_first  = cfg_q[CFG_LSB_FIRST];
  assign busy       = (state_q == LEAD) || (state_q == TRAIL);
  assign start      = bus.reg_dat_we && en_nxt && !busy;
  assign last_bit   = (bit_q == 3'd7);

  mgmt_spi_master_prescaler u_prescaler (
    .clk        (clk),
    .resetn     (resetn),
    .en_i       (busy),
    .prescale_i (cfg_q[7:0]),
    .tick_o     (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? LEAD : IDLE;
      LEAD: begin
        if (!en_nxt)   state_d = IDLE;
        else if (tick) state_d = TRAIL;
      end
      TRAIL: begin
        if (!en_nxt)   state_d = IDLE;
        else if (tick) state_d = last_bit ? DONE : LEAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sck          = cfg_q[CFG_INVSCK] ^ (state_q == TRAIL);
    bus.sdo          = busy & (lsb_first ? tx_q[0] : tx_q[7]);
    bus.csb          = csb_q;
    bus.sdoenb       = csb_q;
    bus.reg_cfg_do   = {busy, 2'b00, cfg_q};
    bus.reg_dat_do   = dat_q;
    bus.reg_dat_wait = (bus.reg_dat_we | bus.reg_dat_re) & busy;
`ifdef MGMT_SPI_MASTER_IRQ_EN
    bus.irq_out      = cfg_q[CFG_IRQ_EN] & (state_q == DONE);
`else
    bus.irq_out      = 1'b0;
`endif
  end

  // Leading edge samples sdi, trailing edge shifts the next bit onto sdo.
  always_comb begin
    tx_d  = tx_q;
    rx_d  = rx_q;
    dat_d = dat_q;
    bit_d = bit_q;
    csb_d = csb_q;
    if (start) begin
      tx_d  = bus.reg_dat_di;
      bit_d = 3'd0;
      csb_d = 1'b0;
    end else if (busy && !en_nxt) begin
      csb_d = 1'b1;
    end else if (busy && tick) begin
      if (state_q == LEAD) begin
        rx_d = lsb_first ? {bus.sdi, rx_q[7:1]} : {rx_q[6:0], bus.sdi};
      end else begin
        tx_d  = lsb_first ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (last_bit) begin
          dat_d = rx_q;
          csb_d = !stream_nxt;
        end
      end
    end else if (!busy && !csb_q && (!stream_nxt || !en_nxt)) begin
      csb_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cfg_q <= cfg_reset_value(DEFAULT_PRESCALE);
      tx_q  <= 8'h00;
      rx_q  <= 8'h00;
      dat_q <= 8'h00;
      bit_q <= 3'd0;
      csb_q <= 1'b1;
    end else begin
      cfg_q <= cfg_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      dat_q <= dat_d;
      bit_q <= bit_d;
      csb_q <= csb_d;
    end
  end

endmodule

// File: tb/tb_mgmt_spi_master.sv
// tb/tb_mgmt_spi_master.sv - self-checking bench for mgmt_spi_master with a byte scoreboard
module tb_mgmt_spi_master;

`ifdef MGMT_SPI_MASTER_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   n_assert = 0;
  int   n_fail = 0;

  mgmt_spi_master_if bus ();

  mgmt_spi_master #(.DEFAULT_PRESCALE(8'd2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  logic [7:0] last_dat = 8'h00;
  logic       cfg_irq_en = 1'b0;
  logic       expect_abort = 1'b0;
  logic       prev_busy = 1'b0;
  logic       mon_busy;
  logic [7:0] mon_exp;
  int         irq_cnt = 0;

  // Flash model: shifts MSB first, advancing on each falling sck while selected.
  logic [7:0] miso_mem [0:7];
  logic [7:0] cmd [0:7];
  logic [5:0] miso_idx = 6'd0;
  logic       prev_sck = 1'b0;
  logic [1:0] sdi_mode;

  always @(bus.csb or bus.sck) begin
    if (bus.csb !== 1'b0) miso_idx = 6'd0;
    else if (prev_sck && !bus.sck) miso_idx = miso_idx + 6'd1;
    prev_sck = bus.sck;
  end

  assign bus.sdi = (sdi_mode == 2'd2) ? 1'b1 :
                   (sdi_mode == 2'd1) ? 1'b0 :
                   miso_mem[miso_idx[5:3]][3'd7 - miso_idx[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      prev_busy = 1'b0;
    end else begin
      mon_busy = bus.reg_cfg_do[15];
      if (bus.irq_out === 1'b1) irq_cnt++;
      if (prev_busy && !mon_busy && !expect_abort) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          check("rx_byte", bus.reg_dat_do, mon_exp);
          last_dat = mon_exp;
        end
        check("irq_at_done", bus.irq_out, IRQ_BUILT & cfg_irq_en);
      end
      prev_busy = mon_busy;
    end
  end

  task automatic cfg_write(input logic [15:0] v);
    bus.reg_cfg_di = v;
    bus.reg_cfg_we = 1'b1;
    @(negedge clk);
    bus.reg_cfg_we = 1'b0;
  endtask

  task automatic dat_write(input logic [7:0] d, input logic [7:0] exp_rx, input bit push);
    int guard = 0;
    bus.reg_dat_di = d;
    bus.reg_dat_we = 1'b1;
    #1;
    while (bus.reg_dat_wait === 1'b1 && guard < 200) begin
      guard++;
      @(negedge clk);
      #1;
    end
    check("write_guard", guard < 200, 1);
    if (push) sb.push_back(exp_rx);
    @(negedge clk);
    bus.reg_dat_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (bus.reg_cfg_do[15] === 1'b1 && g < 2000) begin
      g++;
      @(negedge clk);
    end
    check(tag, g < 2000, 1);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] obs;
    int sck_bad, busy_n, first_idle, stall, g, irq0;

    resetn = 1'b0;
    bus.reg_cfg_we = 1'b0;
    bus.reg_cfg_di = 16'h0000;
    bus.reg_dat_we = 1'b0;
    bus.reg_dat_re = 1'b0;
    bus.reg_dat_di = 8'h00;
    sdi_mode = 2'd1;
    cmd[0] = 8'h03;
    for (int i = 1; i < 8; i++) cmd[i] = 8'h00;
    for (int i = 0; i < 4; i++) miso_mem[i] = 8'h00;
    miso_mem[4] = 8'h93; miso_mem[5] = 8'h01; miso_mem[6] = 8'h00; miso_mem[7] = 8'h13;

    repeat (3) @(negedge clk);
    check("rst_cfg", bus.reg_cfg_do, 16'h0002);
    check("rst_csb", bus.csb, 1);
    check("rst_sck", bus.sck, 0);
    check("rst_sdo", bus.sdo, 0);
    check("rst_sdoenb", bus.sdoenb, 1);
    check("rst_irq", bus.irq_out, 0);
    check("rst_dat", bus.reg_dat_do, 8'h00);
    resetn = 1'b1;
    @(negedge clk);

    // Timing: prescale 4, 0xA5, sdi low
    cfg_write(16'h0804);
    dat_write(8'hA5, 8'h00, 1);
    obs = 8'h00; sck_bad = 0; busy_n = 0; first_idle = -1;
    for (int c = 0; c < 70; c++) begin
      if (c == 0) begin
        check("t_first_sdo", bus.sdo, 1);
        check("t_csb_low", bus.csb, 0);
      end
      if (c == 64) check("t_csb_high_end", bus.csb, 1);
      if ((c % 8) == 4 && c < 64) obs = {obs[6:0], bus.sdo};
      if (bus.sck !== ((c < 64) && ((c % 8) >= 4))) sck_bad++;
      if (bus.reg_cfg_do[15] === 1'b1) busy_n++;
      else if (first_idle < 0) first_idle = c;
      @(negedge clk);
    end
    check("t_sdo_bits", obs, 8'hA5);
    check("t_sck_pattern", sck_bad, 0);
    check("t_busy_cycles", busy_n, 64);
    check("t_busy_clear_at", first_idle, 64);

    // Stall: 0x55 then 0xAA back-to-back, prescale 2, sdi high
    cfg_write(16'h0802);
    sdi_mode = 2'd2;
    dat_write(8'h55, 8'hFF, 1);
    bus.reg_dat_di = 8'hAA;
    bus.reg_dat_we = 1'b1;
    #1;
    stall = 0;
    while (bus.reg_dat_wait === 1'b1 && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    check("s_stall_cycles", stall, 32);
    check("s_busy_clear", bus.reg_cfg_do[15], 0);
    sb.push_back(8'hFF);
    @(negedge clk);
    bus.reg_dat_we = 1'b0;
    check("s_second_busy", bus.reg_cfg_do[15], 1);
    check("s_second_sdo", bus.sdo, 1);
    wait_idle("s_idle");

    // Flash read with stream=1 and stalled reads
    cfg_write(16'h0C02);
    sdi_mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      dat_write(cmd[i], miso_mem[i], 1);
      bus.reg_dat_re = 1'b1;
      #1;
      g = 0;
      while (bus.reg_dat_wait === 1'b1 && g < 200) begin
        g++;
        @(negedge clk);
        #1;
      end
      check($sformatf("f_read%0d", i), bus.reg_dat_do, miso_mem[i]);
      @(negedge clk);
      bus.reg_dat_re = 1'b0;
    end
    check("f_csb_held", bus.csb, 0);
    cfg_write(16'h0802);
    check("f_csb_release", bus.csb, 1);

    // lsb_first + invsck, sdi tied high
    cfg_write(16'h0B02);
    sdi_mode = 2'd2;
    check("l_sck_idle_high", bus.sck, 1);
    dat_write(8'h2D, 8'hFF, 1);
    obs = 8'h00; sck_bad = 0;
    for (int c = 0; c < 32; c++) begin
      if (c == 0) check("l_first_sdo", bus.sdo, 1);
      if ((c % 4) == 2) obs = {bus.sdo, obs[7:1]};
      if (bus.sck !== !((c % 4) >= 2)) sck_bad++;
      @(negedge clk);
    end
    check("l_sdo_bits", obs, 8'h2D);
    check("l_sck_pattern", sck_bad, 0);
    wait_idle("l_idle");
    check("l_sck_idle_after", bus.sck, 1);

    // irq enabled: one pulse per byte (only if built in)
    cfg_write(16'h1802);
    cfg_irq_en = 1'b1;
    check("i_cfg_readback", bus.reg_cfg_do, IRQ_BUILT ? 16'h1802 : 16'h0802);
    sdi_mode = 2'd1;
    irq0 = irq_cnt;
    dat_write(8'h0F, 8'h00, 1);
    wait_idle("i_idle0");
    dat_write(8'hF0, 8'h00, 1);
    wait_idle("i_idle1");
    check("i_irq_on", irq_cnt - irq0, IRQ_BUILT ? 2 : 0);
    cfg_write(16'h0802);
    cfg_irq_en = 1'b0;
    sdi_mode = 2'd2;
    irq0 = irq_cnt;
    dat_write(8'h11, 8'hFF, 1);
    wait_idle("i_idle2");
    check("i_irq_off", irq_cnt - irq0, 0);

    // Abort by clearing enable mid-byte
    sdi_mode = 2'd1;
    dat_write(8'h3C, 8'h00, 0);
    repeat (9) @(negedge clk);
    check("a_busy_before", bus.reg_cfg_do[15], 1);
    expect_abort = 1'b1;
    cfg_write(16'h0002);
    check("a_busy", bus.reg_cfg_do[15], 0);
    check("a_csb", bus.csb, 1);
    check("a_sck", bus.sck, 0);
    check("a_dat_kept", bus.reg_dat_do, last_dat);

    // Write while disabled: ignored, no stall
    bus.reg_dat_di = 8'h77;
    bus.reg_dat_we = 1'b1;
    #1;
    check("d_no_wait", bus.reg_dat_wait, 0);
    @(negedge clk);
    bus.reg_dat_we = 1'b0;
    check("d_no_busy", bus.reg_cfg_do[15], 0);
    check("d_csb", bus.csb, 1);
    @(negedge clk);
    expect_abort = 1'b0;

    // Reset mid-byte with invsck set
    cfg_write(16'h0A02);
    dat_write(8'h81, 8'h00, 0);
    @(negedge clk);
    check("r_sck_pre", bus.sck, 1);
    check("r_sdo_pre", bus.sdo, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("r_cfg", bus.reg_cfg_do, 16'h0002);
    check("r_csb", bus.csb, 1);
    check("r_sdoenb", bus.sdoenb, 1);
    check("r_sck", bus.sck, 0);
    check("r_sdo", bus.sdo, 0);
    check("r_irq", bus.irq_out, 0);
    check("r_dat", bus.reg_dat_do, 8'h00);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mgmt_spi_master.md
MGMT_SPI_MASTER -- requirements
Module: mgmt_spi_master

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEFAULT_PRESCALE, default 8'd2, SHALL set the reset value of cfg[7:0].
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 reg_cfg_we  input  1  write strobe for the configuration register.
REQ-006 reg_cfg_di  input  16  configuration write data.
REQ-007 reg_cfg_do  output  16  configuration readback; bit 15 = busy.
REQ-008 reg_dat_we  input  1  data write strobe; starts a byte transfer.
REQ-009 reg_dat_re  input  1  data read strobe.
REQ-010 reg_dat_di  input  8  transmit byte.
REQ-011 reg_dat_do  output  8  last received byte.
REQ-012 reg_dat_wait  output  1  bus stall request.
REQ-013 sdi  input  1  serial data from slave.
REQ-014 csb  output  1  chip select, active low.
REQ-015 sck  output  1  serial clock.
REQ-016 sdo  output  1  serial data to slave.
REQ-017 sdoenb  output  1  sdo output enable, active low.
REQ-018 irq_out  output  1  transfer-done interrupt pulse.

Function
REQ-019 cfg layout SHALL be: [7:0] prescale, [8] lsb_first, [9] invsck (sck idles high), [10] stream, [11] enable, [12] irq_en; [14:13] SHALL read 0 and [15] SHALL read busy.
REQ-020 Half-period H SHALL be prescale clk cycles, with prescale 0 treated as 1.
REQ-021 A reg_dat_we while enable=1 and idle SHALL load the shift register, set busy, drive csb low and drive the first bit (MSB, or LSB if lsb_first) on sdo in the next cycle.
REQ-022 Each bit SHALL take 2H cycles: the leading sck edge after H cycles samples sdi, and the trailing edge after H more cycles shifts out the next bit. One byte SHALL take exactly 16H cycles.
REQ-023 On the 8th trailing edge, the received byte SHALL be latched into reg_dat_do and busy SHALL clear in the same cycle.
REQ-024 If irq_en=1, irq_out SHALL pulse high for one cycle at that point.
REQ-025 At end of byte, csb SHALL return high in the same cycle if stream=0, and SHALL remain low if stream=1.
REQ-026 While idle with csb low, clearing stream or enable SHALL raise csb in the next cycle.
REQ-027 reg_dat_wait SHALL equal (reg_dat_we | reg_dat_re) & busy (combinational). A stalled write SHALL be accepted in the cycle busy clears; a stalled read SHALL return the new byte.
REQ-028 reg_dat_we while enable=0 SHALL be ignored, without stall.
REQ-029 Clearing enable mid-transfer SHALL abort in the next cycle: busy=0, csb=1, sck=idle level, reg_dat_do unchanged.
REQ-030 sck SHALL sit at its idle level (invsck) whenever no transfer is in progress.
REQ-031 sdoenb SHALL equal csb.
REQ-032 A cfg write and a dat write in the same cycle SHALL apply the cfg write first, so the new enable governs the start.

Reset
REQ-033 On reset: cfg = {0, DEFAULT_PRESCALE}, enable=0, busy=0, csb=1, sck=0, sdo=0, sdoenb=1, irq_out=0, reg_dat_do=8'h00, shift and counters cleared.
REQ-034 Reset asserted mid-transfer SHALL return all outputs to reset values immediately.

Configuration
REQ-035 With macro MGMT_SPI_MASTER_IRQ_EN defined, cfg[12] and irq_out SHALL behave as specified; without it, cfg[12] SHALL read 0, writes to it SHALL be ignored, and irq_out SHALL be tied 0.

Structure
REQ-036 Package mgmt_spi_master_pkg SHALL hold the cfg bit-position constants, the reset cfg value, and the state typedef (IDLE, LEAD, TRAIL, DONE).
REQ-037 One sub-module, mgmt_spi_master_prescaler, SHALL generate the H-cycle half-period tick; shift and FSM logic SHALL live in the top.

Verification
REQ-038 Flash read: cfg enable=1, stream=1, prescale=2; write 0x03, 0x00, 0x00, 0x00, then four 0x00 bytes -> reads return 0x93, 0x01, 0x00, 0x13; clear stream -> csb high next cycle.
REQ-039 Timing: prescale=4, write 0xA5 -> sdo bits 1,0,1,0,0,1,0,1 over 8 sck periods of 8 clk each; busy high for exactly 64 cycles.
REQ-040 Stall: write 0x55 then immediately write 0xAA -> reg_dat_wait high until the first byte completes, and the second transfer starts in the cycle busy clears.
REQ-041 lsb_first=1, invsck=1, sdi tied 1 -> sck idles high, sdo LSB first, reg_dat_do = 0xFF.
REQ-042 Abort/reset: clear enable mid-byte -> csb=1 and busy=0 next cycle; pull resetn low mid-byte -> reset values immediately; irq pulses once per byte only when irq_en=1.
